// File: rtl/alu_ctrl_mdu.sv
// ALU control decoder plus iterative multiply/divide unit with HI/LO
// registers and a pipeline stall handshake.
module alu_ctrl_mdu #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [5:0]        funct_i,
    input  logic [2:0]        ALUOp_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    output logic [3:0]        ALUCtrl_o,
    output logic              jr_o,
    output logic [1:0]        result_sel_o,
    output logic              stall_o,
    output logic              mdu_done_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]     acc_q, acc_d;    // partial product high half / remainder
    logic [DATA_W-1:0]     mq_q, mq_d;      // multiplier / dividend-then-quotient
    logic [DATA_W-1:0]     opd_q, opd_d;    // multiplicand / divisor
    logic                  div_q, div_d;
    logic                  negq_q, negq_d;  // product or quotient is negative
    logic                  negr_q, negr_d;  // remainder is negative
    logic [DATA_W-1:0]     hi_q, hi_d;
    logic [DATA_W-1:0]     lo_q, lo_d;

    logic                  rtype, start, start_div, start_sgn, a_neg, b_neg;
    logic [DATA_W-1:0]     abs_a, abs_b;
    logic [DATA_W:0]       mul_sum, div_shift;
    logic                  div_ge;
    logic [DATA_W-1:0]     step_acc, step_mq;
    logic [2*DATA_W-1:0]   prod_abs, prod_s;
    logic [DATA_W-1:0]     quo_s, rem_s;

    assign rtype     = (ALUOp_i == 3'b010);
    assign start     = valid_i && rtype && (funct_i[5:2] == 4'b0110);
    assign start_div = funct_i[1];
    assign start_sgn = ~funct_i[0];
    assign a_neg     = start_sgn && src1_i[DATA_W-1];
    assign b_neg     = start_sgn && src2_i[DATA_W-1];
    assign abs_a     = a_neg ? -src1_i : src1_i;
    assign abs_b     = b_neg ? -src2_i : src2_i;

    // ALU operation, jr and write-back source decode
    always_comb begin
        ALUCtrl_o    = 4'b1111;
        jr_o         = rtype && (funct_i == 6'b001000);
        result_sel_o = 2'b00;
        if (rtype && funct_i == 6'b010000) result_sel_o = 2'b01;
        if (rtype && funct_i == 6'b010010) result_sel_o = 2'b10;
        case (ALUOp_i)
            3'b000, 3'b011: ALUCtrl_o = 4'b0010;
            3'b001:         ALUCtrl_o = 4'b0110;
            3'b100:         ALUCtrl_o = 4'b0111;
            3'b101:         ALUCtrl_o = 4'b1010;
            3'b110:         ALUCtrl_o = 4'b0001;
            3'b111:         ALUCtrl_o = 4'b0000;
            default: begin
                case (funct_i)
                    6'b100000: ALUCtrl_o = 4'b0010;
                    6'b100010: ALUCtrl_o = 4'b0110;
                    6'b100100: ALUCtrl_o = 4'b0000;
                    6'b100101: ALUCtrl_o = 4'b0001;
                    6'b101010: ALUCtrl_o = 4'b0111;
                    6'b000000: ALUCtrl_o = 4'b1000;
                    6'b000010: ALUCtrl_o = 4'b1001;
                    default:   ALUCtrl_o = 4'b1111;
                endcase
            end
        endcase
    end

    // One shift-add or restoring shift-subtract step, plus sign-corrected final results
    always_comb begin
        mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opd_q} : '0);
        div_shift = {acc_q, mq_q[DATA_W-1]};
        div_ge    = (div_shift >= {1'b0, opd_q});
        if (div_q) begin
            step_acc = div_ge ? DATA_W'(div_shift - {1'b0, opd_q}) : div_shift[DATA_W-1:0];
            step_mq  = {mq_q[DATA_W-2:0], div_ge};
        end else begin
            step_acc = mul_sum[DATA_W:1];
            step_mq  = {mul_sum[0], mq_q[DATA_W-1:1]};
        end
        prod_abs = {step_acc, step_mq};
        prod_s   = negq_q ? -prod_abs : prod_abs;
        quo_s    = negq_q ? -step_mq : step_mq;
        rem_s    = negr_q ? -step_acc : step_acc;
    end

    // MDU sequencing and next-state values; stall covers the start cycle and all of BUSY
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        opd_d   = opd_q;
        div_d   = div_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        stall_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    stall_o = 1'b1;
                    if (start_div && src2_i == '0) begin
                        hi_d    = src1_i;
                        lo_d    = '1;
                        state_d = DONE;
                    end else begin
                        cnt_d   = CNT_W'(DATA_W - 1);
                        acc_d   = '0;
                        mq_d    = start_div ? abs_a : abs_b;
                        opd_d   = start_div ? abs_b : abs_a;
                        div_d   = start_div;
                        negq_d  = a_neg ^ b_neg;
                        negr_d  = a_neg;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                acc_d   = step_acc;
                mq_d    = step_mq;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    if (div_q) begin
                        hi_d = rem_s;
                        lo_d = quo_s;
                    end else begin
                        hi_d = prod_s[2*DATA_W-1:DATA_W];
                        lo_d = prod_s[DATA_W-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            opd_q   <= '0;
            div_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            opd_q   <= opd_d;
            div_q   <= div_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign mdu_done_o = (state_q == DONE);
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Bench for alu_ctrl_mdu: decode vectors checked inline, MDU results
// checked by a scoreboard monitor on each mdu_done_o pulse.
module tb_alu_ctrl_mdu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [5:0]  funct;
    logic [2:0]  aluop;
    logic [31:0] src1, src2;
    logic [3:0]  alu_ctrl;
    logic        jr;
    logic [1:0]  sel;
    logic        stall;
    logic        done;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [1:0]  sel;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    alu_ctrl_mdu #(.DATA_W(32), .CNT_W(6)) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .valid_i     (valid),
        .funct_i     (funct),
        .ALUOp_i     (aluop),
        .src1_i      (src1),
        .src2_i      (src2),
        .ALUCtrl_o   (alu_ctrl),
        .jr_o        (jr),
        .result_sel_o(sel),
        .stall_o     (stall),
        .mdu_done_o  (done),
        .hi_o        (hi),
        .lo_o        (lo)
    );

    always #5 clk = ~clk;

    // {ALUOp, funct, ALUCtrl, jr, result_sel}
    localparam logic [15:0] DEC [0:18] = '{
        {3'b000, 6'h08, 4'h2, 1'b0, 2'b00},
        {3'b001, 6'h00, 4'h6, 1'b0, 2'b00},
        {3'b011, 6'h00, 4'h2, 1'b0, 2'b00},
        {3'b100, 6'h00, 4'h7, 1'b0, 2'b00},
        {3'b101, 6'h00, 4'hA, 1'b0, 2'b00},
        {3'b110, 6'h00, 4'h1, 1'b0, 2'b00},
        {3'b111, 6'h00, 4'h0, 1'b0, 2'b00},
        {3'b000, 6'h10, 4'h2, 1'b0, 2'b00},
        {3'b010, 6'h20, 4'h2, 1'b0, 2'b00},
        {3'b010, 6'h22, 4'h6, 1'b0, 2'b00},
        {3'b010, 6'h24, 4'h0, 1'b0, 2'b00},
        {3'b010, 6'h25, 4'h1, 1'b0, 2'b00},
        {3'b010, 6'h2A, 4'h7, 1'b0, 2'b00},
        {3'b010, 6'h00, 4'h8, 1'b0, 2'b00},
        {3'b010, 6'h02, 4'h9, 1'b0, 2'b00},
        {3'b010, 6'h3F, 4'hF, 1'b0, 2'b00},
        {3'b010, 6'h08, 4'hF, 1'b1, 2'b00},
        {3'b010, 6'h10, 4'hF, 1'b0, 2'b01},
        {3'b010, 6'h12, 4'hF, 1'b0, 2'b10}
    };

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every done pulse consumes one expected result
    always @(negedge clk) begin
        #3;
        if (done === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL mdu_done_unexpected: got pulse hi=%h lo=%h expected no pulse", hi, lo);
            end else begin
                mon_e = sb.pop_front();
                if ({hi, lo, sel} !== mon_e) begin
                    n_fail++;
                    $display("FAIL mdu_result: got hi=%h lo=%h sel=%b expected hi=%h lo=%h sel=%b",
                             hi, lo, sel, mon_e.hi, mon_e.lo, mon_e.sel);
                end
            end
        end
    end

    // Issue one MDU op, hold it while stalled, optionally switch funct mid-stall
    task automatic mdu_op(input string name, input logic [5:0] fn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic [1:0] esel, input int exp_stall,
                          input int mid_at, input logic [5:0] mid_fn);
        exp_t e;
        int   n;
        bit   fin;
        @(negedge clk);
        valid = 1'b1; aluop = 3'b010; funct = fn; src1 = a; src2 = b;
        e.hi = ehi; e.lo = elo; e.sel = esel;
        sb.push_back(e);
        n = 0; fin = 1'b0;
        while (!fin) begin
            #1;
            if (stall !== 1'b1) fin = 1'b1;
            else begin
                n++;
                if (n >= 100) begin
                    fin = 1'b1;
                    n_checks++; n_fail++;
                    $display("FAIL %s_timeout: got stall for %0d cycles expected release", name, n);
                end else begin
                    @(negedge clk);
                    if (n == mid_at) funct = mid_fn;
                end
            end
        end
        chk({name, "_stall_cycles"}, 64'(n), 64'(exp_stall));
        @(negedge clk);
        valid = 1'b0;
        #1;
        chk({name, "_idle_after"}, {62'd0, stall, done}, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; funct = '0; aluop = '0; src1 = '0; src2 = '0;
        #12;
        chk("reset_state", {hi, lo}, 64'd0);
        chk("reset_flags", {62'd0, stall, done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            logic [15:0] v;
            v = DEC[i];
            @(negedge clk);
            aluop = v[15:13]; funct = v[12:7];
            #1;
            chk($sformatf("decode_%0d", i), {57'd0, alu_ctrl, jr, sel}, {57'd0, v[6:0]});
            chk($sformatf("decode_nostall_%0d", i), {63'd0, stall}, 64'd0);
        end

        mdu_op("mult_neg", 6'h18, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 2'b00, 33, 0, 6'h18);
        mdu_op("divu", 6'h1B, 32'd100, 32'd7, 32'd2, 32'd14, 2'b00, 33, 0, 6'h1B);
        mdu_op("div_neg", 6'h1A, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 2'b00, 33, 0, 6'h1A);
        mdu_op("div_ovf", 6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 2'b00, 33, 0, 6'h1A);
        mdu_op("div_zero", 6'h1A, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 2'b00, 1, 0, 6'h1A);
        mdu_op("mflo_mid", 6'h19, 32'h12345678, 32'h10, 32'd1, 32'h23456780, 2'b10, 33, 5, 6'h12);

        // mfhi while idle: selects HI, never stalls
        @(negedge clk);
        valid = 1'b1; aluop = 3'b010; funct = 6'h10;
        #1;
        chk("mfhi_idle", {61'd0, stall, sel}, {61'd0, 1'b0, 2'b01});
        @(negedge clk);
        valid = 1'b0;

        // Reset in the middle of BUSY aborts the operation
        @(negedge clk);
        valid = 1'b1; aluop = 3'b010; funct = 6'h19; src1 = 32'h1234; src2 = 32'h5678;
        repeat (11) @(negedge clk);
        rst_n = 1'b0; valid = 1'b0;
        #1;
        chk("rst_mid_busy_hilo", {hi, lo}, 64'd0);
        chk("rst_mid_busy_flags", {62'd0, stall, done}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("post_rst_idle", {62'd0, stall, done}, 64'd0);

        mdu_op("multu_after_rst", 6'h19, 32'hFFFFFFFF, 32'd2, 32'd1, 32'hFFFFFFFE, 2'b00, 33, 0, 6'h19);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
